// File: rtl/fpu_pkg.sv
// Shared constants and stage types for the round-and-pack pipeline.
package fpu_pkg;

    typedef enum logic [1:0] {
        RmRne = 2'd0,
        RmRtz = 2'd1,
        RmRup = 2'd2,
        RmRdn = 2'd3
    } rm_e;

    localparam int unsigned BiasDouble = 1023;
    localparam int unsigned BiasSingle = 127;
    localparam int unsigned BiasDiff   = BiasDouble - BiasSingle;

    localparam logic [63:0] NanDouble = 64'h7FF7_FFFF_FFFF_FFFF;
    localparam logic [31:0] NanSingle = 32'h7FBF_FFFF;
    localparam logic [62:0] MaxDouble = 63'h7FEF_FFFF_FFFF_FFFF;
    localparam logic [30:0] MaxSingle = 31'h7F7F_FFFF;

    localparam logic signed [13:0] ExpOvfDouble = 14'sd2047;
    localparam logic signed [13:0] ExpOvfSingle = 14'sd255;

    // Stage-1 register contents: extracted fields ready for rounding.
    typedef struct packed {
        logic        sign;
        logic        fmt;
        rm_e         rm;
        logic        invalid;
        logic        zero;
        logic        tiny;
        logic [12:0] exp;
        logic        hid;
        logic [51:0] man;
        logic        g;
        logic        s;
    } s1_t;

    typedef struct packed {
        logic [63:0] result;
        logic        ix;
        logic        uf;
        logic        of;
        logic        nv;
    } s2_t;

endpackage

// File: rtl/f_rshift_sticky.sv
// 108-bit logical right shift; sticky_o is the OR of every bit shifted out.
module f_rshift_sticky (
    input  logic [107:0] data_i,
    input  logic [5:0]   shamt_i,
    output logic [107:0] data_o,
    output logic         sticky_o
);

    logic [107:0] mask;

    always_comb begin
        mask     = ~({108{1'b1}} << shamt_i);
        data_o   = data_i >> shamt_i;
        sticky_o = |(data_i & mask);
    end

endmodule

// File: rtl/f_round_pack.sv
// Two-stage round and pack of a normalized magnitude into IEEE single/double.
// Define FPU_SUBNORMAL_EN to denormalize tiny results instead of flushing them to zero.
module f_round_pack #(
    parameter int unsigned info_width = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_wait,
    input  logic                  flush,
    output logic                  busy,
    input  logic                  fmt,
    input  logic [1:0]            rm,
    input  logic [107:0]          in_frac,
    input  logic [12:0]           in_exp,
    input  logic                  in_sign,
    input  logic                  in_invalid,
    input  logic [info_width-1:0] info_in,
    output logic [63:0]           result,
    output logic                  flag_inexact,
    output logic                  flag_underflow,
    output logic                  flag_overflow,
    output logic                  flag_invalid,
    output logic [info_width-1:0] info_out
);

    import fpu_pkg::*;

    s1_t s1_q, s1_d, s1_new;
    s2_t s2_q, s2_d, s2_new;
    logic [info_width-1:0] info1_q, info1_d, info2_q, info2_d;

    logic signed [12:0] e_raw, e_s1;
    logic               tiny;
    logic [107:0]       frac_n;
    logic               sticky;
    logic               unused_bits;

    always_comb begin
        e_raw = fmt ? $signed(in_exp) : $signed(in_exp - 13'(BiasDiff));
        tiny  = (e_raw <= 13'sd0);
    end

`ifdef FPU_SUBNORMAL_EN
    localparam logic SubnormalEn = 1'b1;

    logic signed [13:0] sh_full;
    logic [5:0]         sh_amt;
    logic [107:0]       frac_sh;
    logic               sticky_sh;

    always_comb begin
        sh_full = 14'sd1 - $signed({e_raw[12], e_raw});
        sh_amt  = (sh_full > 14'sd63) ? 6'd63 : sh_full[5:0];
    end

    f_rshift_sticky u_rshift (
        .data_i   (in_frac),
        .shamt_i  (sh_amt),
        .data_o   (frac_sh),
        .sticky_o (sticky_sh)
    );

    always_comb begin
        frac_n = tiny ? frac_sh : in_frac;
        sticky = tiny & sticky_sh;
        e_s1   = tiny ? 13'sd0 : e_raw;
    end
`else
    localparam logic SubnormalEn = 1'b0;

    always_comb begin
        frac_n = in_frac;
        sticky = 1'b0;
        e_s1   = e_raw;
    end
`endif

    assign unused_bits = ^frac_n[107:106];

    // Stage 1: field extraction plus stall/flush handling of both stages' tags.
    always_comb begin
        s1_new         = '0;
        s1_new.sign    = in_sign;
        s1_new.fmt     = fmt;
        s1_new.rm      = rm_e'(rm);
        s1_new.invalid = in_invalid;
        s1_new.zero    = ~in_frac[105];
        s1_new.tiny    = tiny;
        s1_new.exp     = e_s1;
        s1_new.hid     = frac_n[105];
        if (fmt) begin
            s1_new.man = frac_n[104:53];
            s1_new.g   = frac_n[52];
            s1_new.s   = (|frac_n[51:0]) | sticky;
        end else begin
            s1_new.man = {29'd0, frac_n[104:82]};
            s1_new.g   = frac_n[81];
            s1_new.s   = (|frac_n[80:0]) | sticky;
        end

        s1_d    = a_wait ? s1_q : s1_new;
        info1_d = a_wait ? info1_q : info_in;
        info2_d = a_wait ? info2_q : info1_q;
        if (flush) begin
            info1_d[0] = 1'b0;
            info2_d[0] = 1'b0;
        end
    end

    logic               inc, lsb, carry, hid_r, ovf, to_inf, tiny_to_zero;
    logic [53:0]        sum_d;
    logic [24:0]        sum_s;
    logic signed [13:0] e_r;
    logic [63:0]        zero_res;

    // Stage 2: round, detect overflow, and pack.
    always_comb begin
        lsb = s1_q.man[0];
        inc = 1'b0;
        unique case (s1_q.rm)
            RmRne: inc = s1_q.g & (s1_q.s | lsb);
            RmRtz: inc = 1'b0;
            RmRup: inc = ~s1_q.sign & (s1_q.g | s1_q.s);
            RmRdn: inc = s1_q.sign & (s1_q.g | s1_q.s);
        endcase

        sum_d = {1'b0, s1_q.hid, s1_q.man} + 54'(inc);
        sum_s = {1'b0, s1_q.hid, s1_q.man[22:0]} + 25'(inc);
        carry = s1_q.fmt ? sum_d[53] : sum_s[24];
        hid_r = s1_q.fmt ? sum_d[52] : sum_s[23];

        // A subnormal that rounds up into the hidden bit becomes the smallest normal.
        if (s1_q.exp == 13'd0 && hid_r) begin
            e_r = 14'sd1;
        end else begin
            e_r = $signed({s1_q.exp[12], s1_q.exp}) + $signed({13'd0, carry});
        end

        ovf    = s1_q.fmt ? (e_r >= ExpOvfDouble) : (e_r >= ExpOvfSingle);
        to_inf = (s1_q.rm == RmRne) | ((s1_q.rm == RmRup) & ~s1_q.sign)
               | ((s1_q.rm == RmRdn) & s1_q.sign);
        tiny_to_zero = s1_q.tiny & ~SubnormalEn;
        zero_res = s1_q.fmt ? {s1_q.sign, 63'd0} : {32'd0, s1_q.sign, 31'd0};

        s2_new = '0;
        if (s1_q.invalid) begin
            s2_new.result = s1_q.fmt ? NanDouble : {32'd0, NanSingle};
            s2_new.nv     = 1'b1;
        end else if (s1_q.zero) begin
            s2_new.result = zero_res;
        end else if (tiny_to_zero) begin
            s2_new.result = zero_res;
            s2_new.ix     = 1'b1;
            s2_new.uf     = 1'b1;
        end else if (ovf) begin
            s2_new.ix = 1'b1;
            s2_new.of = 1'b1;
            if (to_inf) begin
                s2_new.result = s1_q.fmt ? {s1_q.sign, 11'h7FF, 52'd0}
                                         : {32'd0, s1_q.sign, 8'hFF, 23'd0};
            end else begin
                s2_new.result = s1_q.fmt ? {s1_q.sign, MaxDouble} : {32'd0, s1_q.sign, MaxSingle};
            end
        end else begin
            s2_new.ix     = s1_q.g | s1_q.s;
            s2_new.uf     = s1_q.tiny & (s1_q.g | s1_q.s);
            s2_new.result = s1_q.fmt ? {s1_q.sign, e_r[10:0], sum_d[51:0]}
                                     : {32'd0, s1_q.sign, e_r[7:0], sum_s[22:0]};
        end

        s2_d = a_wait ? s2_q : s2_new;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            info1_q <= '0;
            info2_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            info1_q <= info1_d;
            info2_q <= info2_d;
        end
    end

    assign busy           = a_wait;
    assign result         = s2_q.result;
    assign flag_inexact   = s2_q.ix;
    assign flag_underflow = s2_q.uf;
    assign flag_overflow  = s2_q.of;
    assign flag_invalid   = s2_q.nv;
    assign info_out       = info2_q;

endmodule

// File: doc/f_round_pack.md
F_ROUND_PACK -- requirements
Module: f_round_pack

Interface
REQ-001 Parameter: info_width, default 1, width of the sideband tag carried alongside each operation; bit 0 is the valid bit.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 a_wait  in  1  stall; when 1, all pipeline registers hold.
REQ-005 flush  in  1  clears the info bit 0 of every stage; data and other info bits are untouched.
REQ-006 busy  out  1  equals a_wait.
REQ-007 fmt  in  1  0 = single, 1 = double.
REQ-008 rm  in  2  rounding mode: 0 = RN (ties-to-even), 1 = RZ, 2 = RP, 3 = RM.
REQ-009 in_frac  in  108  normalized unsigned magnitude; leading 1 at bit 105, or all-zero for a zero value.
REQ-010 in_exp  in  13  two's-complement linear exponent, bias 1023, with no special encodings.
REQ-011 in_sign / in_invalid / info_in  in  1 / 1 / info_width  sign, invalid-operation marker, sideband tag.
REQ-012 result  out  64  packed IEEE-754 value; single results occupy [31:0] with [63:32] = 0.
REQ-013 flag_inexact / flag_underflow / flag_overflow / flag_invalid  out  1 each  exception flags for the result.
REQ-014 info_out  out  info_width  tag aligned with result.

Function
REQ-015 Latency: exactly 2 unstalled cycles from input to output.
REQ-016 When a_wait = 1, no stage advances, and outputs hold their values.
REQ-017 flush has priority over a_wait for info bit 0 in both stages; flush and a valid input in the same cycle drop that input.
REQ-018 Stage 1 computes the biased exponent E as follows: E = in_exp for double; E = in_exp - 896 for single (13-bit signed).
REQ-019 Stage 1 handles tininess: if E <= 0, the mantissa is right-shifted by 1-E (saturating at 63); all bits shifted out are ORed into sticky, and E is forced to 0.
REQ-020 Stage 1 extracts fields: double uses m = frac[104:53], g = frac[52], s = |frac[51:0]; single uses m = frac[104:82], g = frac[81], s = |frac[80:0]; the hidden bit is frac[105].
REQ-021 Stage 2 increments under these conditions: RN when g & (s | lsb); RZ never; RP when ~sign & (g|s); RM when sign & (g|s).
REQ-022 A carry-out of the hidden bit increments E and leaves the mantissa all zero; a subnormal that rounds into the hidden bit yields E = 1.
REQ-023 Overflow occurs when E >= 2047 (double) or E >= 255 (single). flag_overflow and flag_inexact are set. The result is Inf for RN, or for RP with a positive sign, or for RM with a negative sign; otherwise it is the largest finite value (0x7FEFFFFFFFFFFFFF / 0x7F7FFFFF, with the sign applied).
REQ-024 flag_inexact = g | s, or overflow.
REQ-025 flag_underflow = tiny (E <= 0 before rounding) & inexact.
REQ-026 in_invalid = 1 forces the default NaN: 0x7FF7FFFFFFFFFFFF for double, 0x7FBFFFFF for single. flag_invalid is set and all other flags are 0.
REQ-027 in_frac[105] = 0 with in_invalid = 0 produces a signed zero with no flags.

Reset
REQ-028 While reset is asserted, all stage registers are cleared asynchronously: result = 0, all flags = 0, and info_out = 0.
REQ-029 Reset asserted mid-operation discards all in-flight operations; no valid output appears until 2 cycles after a new valid input.

Configuration
REQ-030 Macro FPU_SUBNORMAL_EN: when defined, tiny results are denormalized and rounded per REQ-019..REQ-025.
REQ-031 When FPU_SUBNORMAL_EN is undefined, every tiny result becomes a signed zero with flag_underflow = flag_inexact = 1, and the denormal shifter is not instantiated.

Structure
REQ-032 Package fpu_pkg holds the following: rounding-mode encodings, the bias constants 1023/127/896, the default-NaN constants, and the max-finite constants.
REQ-033 One sub-module, f_rshift_sticky (108-bit right shift by a 6-bit amount, with a sticky OR-out), is used by stage 1.

Verification
REQ-034 Unit value: in_frac = 1<<105, in_exp = 1023, fmt = 1, rm = RN -> result 0x3FF0000000000000 after 2 cycles, with no flags.
REQ-035 Tie-to-even: double with lsb = 0, g = 1, s = 0 under RN -> no increment and flag_inexact = 1; the same input with lsb = 1 increments.
REQ-036 Carry-out: in_frac[105:53] all ones, g = 1, in_exp = 1023, RN -> result 0x4000000000000000 with flag_inexact = 1.
REQ-037 Overflow: in_exp = 2047, rm = RN -> 0x7FF0000000000000; with rm = RZ -> 0x7FEFFFFFFFFFFFFF; overflow and inexact are set in both cases.
REQ-038 Subnormal: in_exp = 0, in_frac = 1<<105, double -> 0x0008000000000000 with no flags (macro defined); with the macro undefined -> 0x0000000000000000 with underflow = inexact = 1.
REQ-039 Stall/flush: assert a_wait for 3 cycles mid-stream -> outputs hold and order is preserved; pulse flush with 2 ops in flight -> both emerge with info_out[0] = 0.
